conv_scheduler: RTL and testbench

- Sequences the combinational 2x2 Convolution datapath (four 4-bit IFM, four 4-bit INW, 10-bit Output) over a streamed IMG_W x IMG_H image of 4-bit pixels.
- Operation: load a 2x2 kernel, accept pixels in raster order, buffer one row, present every stride-1 2x2 window to the datapath, and register the results as an output stream.
- Position: sits between the pixel source and the Convolution instance; drives that instance's inputs and receives its Output.

---
 rtl/conv_scheduler.sv | 156 +++++++++++++++
 tb/tb_conv_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_scheduler.sv
// conv_scheduler: streams an IMG_W x IMG_H image of 4-bit pixels through an
// external combinational 2x2 convolution datapath.
//   start            : begin a job (sampled in IDLE)
//   w_valid/w_data   : four kernel weight beats, captured into inw_0..inw_3
//   in_valid/in_data : raster-order pixels, accepted when in_ready is high
//   ifm_0..ifm_3     : current 2x2 window driven to the datapath
//   conv_out         : datapath result, registered into out_data
//   out_valid/out_last/out_data : result stream, one pulse per window
//   busy/done        : job in progress / one-cycle pulse on completion
module conv_scheduler #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       w_valid,
  input  logic [3:0] w_data,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [3:0] ifm_0,
  output logic [3:0] ifm_1,
  output logic [3:0] ifm_2,
  output logic [3:0] ifm_3,
  output logic [3:0] inw_0,
  output logic [3:0] inw_1,
  output logic [3:0] inw_2,
  output logic [3:0] inw_3,
  input  logic [9:0] conv_out,
  output logic       out_valid,
  output logic [9:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW  = $clog2(IMG_W);
  localparam int unsigned RW  = $clog2(IMG_H);
  localparam int unsigned LBD = IMG_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, FLUSH} state_t;

  state_t        state, state_d;
  logic          in_ready_d, busy_d, done_d;
  logic [1:0]    widx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [3:0]    lb [LBD];
  logic          win_v, win_last;

  logic accept_c, last_pix_c, win_ok_c;

  assign accept_c   = in_valid && in_ready && (state == STREAM);
  assign last_pix_c = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
  assign win_ok_c   = (row != '0) && (col != '0);

  // Next-state and next registered control outputs.
  always_comb begin
    state_d    = state;
    in_ready_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state)
      IDLE:    if (start) state_d = LOAD_W;
      LOAD_W:  if (w_valid && (widx == 2'd3)) state_d = STREAM;
      STREAM:  if (accept_c && last_pix_c) state_d = FLUSH;
      FLUSH:   if (out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == STREAM);
    busy_d     = (state_d != IDLE);
    done_d     = (state == FLUSH) && (state_d == IDLE);
  end

  // State, control outputs, weights, counters and result pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      widx      <= 2'd0;
      inw_0     <= 4'd0;
      inw_1     <= 4'd0;
      inw_2     <= 4'd0;
      inw_3     <= 4'd0;
      row       <= '0;
      col       <= '0;
      ifm_0     <= 4'd0;
      ifm_1     <= 4'd0;
      ifm_2     <= 4'd0;
      ifm_3     <= 4'd0;
      win_v     <= 1'b0;
      win_last  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 10'd0;
    end else begin
      state    <= state_d;
      in_ready <= in_ready_d;
      busy     <= busy_d;
      done     <= done_d;

      if (state == IDLE) begin
        widx <= 2'd0;
        row  <= '0;
        col  <= '0;
      end

      if ((state == LOAD_W) && w_valid) begin
        case (widx)
          2'd0:    inw_0 <= w_data;
          2'd1:    inw_1 <= w_data;
          2'd2:    inw_2 <= w_data;
          default: inw_3 <= w_data;
        endcase
        widx <= widx + 2'd1;
      end

      if (accept_c) begin
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      // lb[0] is the previous pixel, lb[IMG_W-1] the one above, lb[IMG_W] above-left.
      if (accept_c && win_ok_c) begin
        ifm_0 <= lb[IMG_W];
        ifm_1 <= lb[IMG_W-1];
        ifm_2 <= lb[0];
        ifm_3 <= in_data;
      end
      win_v    <= accept_c && win_ok_c;
      win_last <= accept_c && last_pix_c;

      out_valid <= win_v;
      out_last  <= win_last;
      if (win_v) out_data <= conv_out;
    end
  end

  // Row line buffer: shifts once per accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LBD); i++) lb[i] <= 4'd0;
    end else if (accept_c) begin
      lb[0] <= in_data;
      for (int i = 1; i < int'(LBD); i++) lb[i] <= lb[i-1];
    end
  end

endmodule

// File: tb/tb_conv_scheduler.sv
// Self-checking bench for conv_scheduler with a behavioural 2x2 datapath.
module tb_conv_scheduler;

  localparam int unsigned IMG_W = 8;
  localparam int unsigned IMG_H = 8;
  localparam int NWIN = (IMG_W - 1) * (IMG_H - 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       w_valid = 1'b0;
  logic [3:0] w_data = 4'd0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_ready;
  logic [3:0] ifm_0, ifm_1, ifm_2, ifm_3;
  logic [3:0] inw_0, inw_1, inw_2, inw_3;
  logic [9:0] conv_out;
  logic       out_valid;
  logic [9:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;

  conv_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .w_valid(w_valid), .w_data(w_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ifm_0(ifm_0), .ifm_1(ifm_1), .ifm_2(ifm_2), .ifm_3(ifm_3),
    .inw_0(inw_0), .inw_1(inw_1), .inw_2(inw_2), .inw_3(inw_3),
    .conv_out(conv_out),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  // Behavioural Convolution datapath.
  assign conv_out = 10'(ifm_0) * 10'(inw_0) + 10'(ifm_1) * 10'(inw_1)
                  + 10'(ifm_2) * 10'(inw_2) + 10'(ifm_3) * 10'(inw_3);

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    bit last;
    int cyc;
  } exp_t;

  typedef struct {
    logic [15:0] w;        // w[3:0] = first beat (inw_0)
    int          mode;     // 0: constant pixels, 1: ramp (8r+c) mod 16
    int          cval;
    bit          gaps;
    bit          disturb;
    bit          idle_wv;
    int          exp_const; // expected out_data for every window, -1 = use model
  } job_t;

  exp_t sb[$];
  int   img[IMG_H][IMG_W];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_out, n_last, n_done, last_cyc, done_cyc;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " in_ready"}, in_ready, 0);
    chk({tag, " ifm"}, {ifm_0, ifm_1, ifm_2, ifm_3}, 0);
    chk({tag, " inw"}, {inw_0, inw_1, inw_2, inw_3}, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_data"}, out_data, 0);
    chk({tag, " out_last"}, out_last, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
  endtask

  // Output monitor: pops the scoreboard on every out_valid pulse.
  always @(negedge clk) begin
    if (out_valid) begin
      n_out++;
      if (out_last) begin
        n_last++;
        last_cyc = cyc;
      end
      if (sb.size() == 0) begin
        chk("unexpected out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_last", out_last, e.last);
        chk("latency", cyc, e.cyc);
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  function automatic int pix(input int mode, input int cval, input int r, input int c);
    return (mode == 0) ? cval : ((8 * r + c) % 16);
  endfunction

  task automatic run_job(input job_t jb, input int abort_after);
    int p, t, guard, r, c, npix;
    exp_t e;
    n_out = 0; n_last = 0; n_done = 0; last_cyc = -1; done_cyc = -1;
    sb.delete();
    npix = (abort_after > 0) ? abort_after : int'(IMG_W * IMG_H);

    @(negedge clk);
    start = 1'b1; w_valid = jb.idle_wv; w_data = 4'd9;
    @(negedge clk);
    start = 1'b0; w_valid = 1'b0;
    chk("busy after start", busy, 1);
    chk("in_ready in LOAD_W", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); w_valid = 1'b1; w_data = jb.w[4*i +: 4];
      @(negedge clk); w_valid = 1'b0;
    end
    chk("inw after load", {inw_3, inw_2, inw_1, inw_0}, jb.w);
    chk("in_ready in STREAM", in_ready, 1);

    p = 0; t = 0; guard = 0;
    while (p < npix && guard < 2000) begin
      @(negedge clk);
      guard++;
      in_valid = 1'b0; start = 1'b0; w_valid = 1'b0;
      if (jb.disturb && (t % 5 == 2)) begin
        start = 1'b1; w_valid = 1'b1; w_data = 4'd7;
      end
      if (!jb.gaps || (t % 3 == 0)) begin
        r = p / int'(IMG_W);
        c = p % int'(IMG_W);
        in_valid = 1'b1;
        in_data = 4'(pix(jb.mode, jb.cval, r, c));
        if (in_ready) begin
          img[r][c] = int'(in_data);
          if (r >= 1 && c >= 1) begin
            if (jb.exp_const >= 0) e.data = jb.exp_const;
            else e.data = int'(jb.w[3:0]) * img[r-1][c-1] + int'(jb.w[7:4]) * img[r-1][c]
                        + int'(jb.w[11:8]) * img[r][c-1] + int'(jb.w[15:12]) * img[r][c];
            e.last = (r == int'(IMG_H) - 1) && (c == int'(IMG_W) - 1);
            e.cyc  = cyc + 2;
            sb.push_back(e);
          end
          p++;
        end
      end
      t++;
    end
    if (guard >= 2000) chk("stream timeout", p, npix);
    if (abort_after > 0) return;

    @(negedge clk);
    in_valid = 1'b0; start = 1'b0; w_valid = 1'b0;
    chk("in_ready after last pixel", in_ready, 0);
    chk("busy in FLUSH", busy, 1);
    guard = 0;
    while (n_done == 0 && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("done seen", n_done, 1);
    chk("done after out_last", done_cyc, last_cyc + 1);
    chk("window count", n_out, NWIN);
    chk("out_last count", n_last, 1);
    chk("scoreboard empty", sb.size(), 0);
    @(negedge clk); #1;
    chk("done pulse width", done, 0);
    chk("busy idle", busy, 0);
    chk("weights persist", {inw_3, inw_2, inw_1, inw_0}, jb.w);
  endtask

  job_t jobs[5];
  job_t rj;

  initial begin
    jobs[0] = '{16'h1111, 0, 15, 1'b0, 1'b0, 1'b0, 60};
    jobs[1] = '{16'hFFFF, 0, 15, 1'b0, 1'b0, 1'b1, 900};
    jobs[2] = '{16'h0001, 1, 0,  1'b0, 1'b0, 1'b0, -1};
    jobs[3] = '{16'h0001, 1, 0,  1'b1, 1'b0, 1'b0, -1};
    jobs[4] = '{16'h1111, 0, 15, 1'b0, 1'b1, 1'b0, 60};

    #12;
    chk_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    for (int j = 0; j < 5; j++) run_job(jobs[j], 0);

    // Reset in the middle of a job.
    rj = '{16'h1111, 0, 5, 1'b0, 1'b0, 1'b0, 20};
    run_job(rj, 20);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("mid-op reset");
    sb.delete();
    n_out = 0; n_last = 0; n_done = 0;
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("outputs after reset", n_out, 0);
    chk("done after reset", n_done, 0);

    rj = '{16'h0002, 0, 3, 1'b0, 1'b0, 1'b0, 6};
    run_job(rj, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
